// File: rtl/vga_timing_pkg.sv
// Shared V-phase encoding, default 640x480@60 timing constants and the total-length helper
// for the VGA timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    V_ACT   = 2'd0,
    V_FRONT = 2'd1,
    V_SYNCP = 2'd2,
    V_BACK  = 2'd3
  } vphase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One wrapping counter axis with terminal-count flag and a registered sync-window decode aligned to the count.
// Advances only while en is high; count and sync hold otherwise.
module timing_axis #(
  parameter int   TOTAL      = 800,
  parameter int   SYNC_START = 656,
  parameter int   SYNC_END   = 752,
  parameter logic POL        = 1'b0,
  parameter int   CW         = 10
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          tc,
  output logic          sync
);

  localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
  localparam logic [CW:0]   WIN_LO = (CW+1)'(SYNC_START);
  localparam logic [CW:0]   WIN_HI = (CW+1)'(SYNC_END);

  logic in_win;

  assign tc        = (count == LAST);
  assign count_nxt = tc ? '0 : count + CW'(1);
  // Decode the value about to be loaded so sync describes the same cycle as count.
  assign in_win    = ({1'b0, count_nxt} >= WIN_LO) && ({1'b0, count_nxt} < WIN_HI);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      sync  <= ~POL;
    end else if (en) begin
      count <= count_nxt;
      sync  <= in_win ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, V-phase FSM and registered sync/blank decodes with zero latency to the counts.
// pix_en gates all state; line_end/frame_end are combinational and only pulse on enabled edges.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_end,
  output logic          frame_end
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] V_FRONT_AT = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_AT  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_BACK_AT  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0]   H_VIS      = (CW+1)'(H_ACTIVE);

  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_cfg_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW-bit counters");
  end

  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          h_tc;
  logic          v_tc;
  logic          h_wrap;
  logic          v_win;
  vphase_t       phase;
  vphase_t       phase_nxt;

  assign h_wrap    = pix_en & h_tc;
  assign line_end  = h_wrap;
  assign frame_end = h_wrap & v_tc;

  timing_axis #(
    .TOTAL     (H_TOTAL),
    .SYNC_START(H_ACTIVE + H_FP),
    .SYNC_END  (H_ACTIVE + H_FP + H_SYNC),
    .POL       (HS_POL),
    .CW        (CW)
  ) u_h_axis (
    .Clk      (Clk),
    .reset    (reset),
    .en       (pix_en),
    .count    (hcount),
    .count_nxt(h_nxt),
    .tc       (h_tc),
    .sync     (hsync)
  );

  timing_axis #(
    .TOTAL     (V_TOTAL),
    .SYNC_START(V_ACTIVE + V_FP),
    .SYNC_END  (V_ACTIVE + V_FP + V_SYNC),
    .POL       (VS_POL),
    .CW        (CW)
  ) u_v_axis (
    .Clk      (Clk),
    .reset    (reset),
    .en       (h_wrap),
    .count    (vcount),
    .count_nxt(v_nxt),
    .tc       (v_tc),
    .sync     (v_win)
  );

  // Phase only moves on a line wrap, keyed on the vcount about to be loaded.
  always_comb begin
    phase_nxt = phase;
    if (h_wrap) begin
      case (phase)
        V_ACT:   if (v_nxt == V_FRONT_AT) phase_nxt = V_FRONT;
        V_FRONT: if (v_nxt == V_SYNC_AT)  phase_nxt = V_SYNCP;
        V_SYNCP: if (v_nxt == V_BACK_AT)  phase_nxt = V_BACK;
        V_BACK:  if (v_nxt == '0)         phase_nxt = V_ACT;
        default: phase_nxt = V_ACT;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      phase    <= V_ACT;
      vsync    <= ~VS_POL;
      video_on <= 1'b1;
    end else if (pix_en) begin
      phase    <= phase_nxt;
      vsync    <= (phase_nxt == V_SYNCP) ? VS_POL : ~VS_POL;
      video_on <= ({1'b0, h_nxt} < H_VIS) && (phase_nxt == V_ACT);
    end
  end

  // The vertical axis window and the FSM-driven vsync must always agree.
  a_vsync_window: assert property (@(posedge Clk) disable iff (reset) (v_win == vsync));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing and small-timing instances against a linear-position raster model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct {int hc; int vc; int hs; int vs; int vo; int le; int fe;} obs_t;
  typedef struct {int en; obs_t exp;} vec_t;

  localparam int DHT = 800;
  localparam int DVT = 525;
  localparam int SHT = 8;
  localparam int SVT = 6;

  logic       Clk = 1'b0;
  logic       reset;
  logic       pix_en_d, pix_en_s;
  logic [9:0] d_hcount, d_vcount;
  logic       d_hsync, d_vsync, d_video_on, d_line_end, d_frame_end;
  logic [3:0] s_hcount, s_vcount;
  logic       s_hsync, s_vsync, s_video_on, s_line_end, s_frame_end;

  int checks = 0;
  int failures = 0;
  int pd = 0;
  int ps = 0;

  always #5 Clk = ~Clk;

  vga_timing_gen d_dut (
    .Clk(Clk), .reset(reset), .pix_en(pix_en_d),
    .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
    .video_on(d_video_on), .line_end(d_line_end), .frame_end(d_frame_end)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
  ) s_dut (
    .Clk(Clk), .reset(reset), .pix_en(pix_en_s),
    .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
    .video_on(s_video_on), .line_end(s_line_end), .frame_end(s_frame_end)
  );

  // Raster position p = enabled edges since reset; every output follows from p alone.
  function automatic obs_t mdl(input int p, input logic en, input int ha, hf, hw, hb,
                               input int va, vf, vw, vb, input int hp, vp);
    obs_t o;
    int ht;
    int vt;
    ht   = ha + hf + hw + hb;
    vt   = va + vf + vw + vb;
    o.hc = p % ht;
    o.vc = p / ht;
    o.hs = (o.hc >= ha + hf && o.hc < ha + hf + hw) ? hp : 1 - hp;
    o.vs = (o.vc >= va + vf && o.vc < va + vf + vw) ? vp : 1 - vp;
    o.vo = (o.hc < ha && o.vc < va) ? 1 : 0;
    o.le = (en && o.hc == ht - 1) ? 1 : 0;
    o.fe = (o.le == 1 && o.vc == vt - 1) ? 1 : 0;
    return o;
  endfunction

  function automatic int exp_phase(input int vc);
    if (vc < 3) return int'(V_ACT);
    if (vc == 3) return int'(V_FRONT);
    if (vc == 4) return int'(V_SYNCP);
    return int'(V_BACK);
  endfunction

  function automatic obs_t obs_d();
    obs_t o;
    o.hc = int'(d_hcount); o.vc = int'(d_vcount); o.hs = int'(d_hsync); o.vs = int'(d_vsync);
    o.vo = int'(d_video_on); o.le = int'(d_line_end); o.fe = int'(d_frame_end);
    return o;
  endfunction

  function automatic obs_t obs_s();
    obs_t o;
    o.hc = int'(s_hcount); o.vc = int'(s_vcount); o.hs = int'(s_hsync); o.vs = int'(s_vsync);
    o.vo = int'(s_video_on); o.le = int'(s_line_end); o.fe = int'(s_frame_end);
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_obs(input string t, input obs_t a, input obs_t e);
    chk({t, ".hcount"}, a.hc, e.hc);
    chk({t, ".vcount"}, a.vc, e.vc);
    chk({t, ".hsync"}, a.hs, e.hs);
    chk({t, ".vsync"}, a.vs, e.vs);
    chk({t, ".video_on"}, a.vo, e.vo);
    chk({t, ".line_end"}, a.le, e.le);
    chk({t, ".frame_end"}, a.fe, e.fe);
  endtask

  task automatic cmp_all(input string t);
    obs_t es;
    es = mdl(ps, pix_en_s, 4, 1, 2, 1, 3, 1, 1, 1, 1, 1);
    cmp_obs({t, "/d"}, obs_d(), mdl(pd, pix_en_d, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0));
    cmp_obs({t, "/s"}, obs_s(), es);
    chk({t, "/s.phase"}, int'(s_dut.phase), exp_phase(es.vc));
  endtask

  task automatic apply(input logic en_d, input logic en_s);
    pix_en_d = en_d;
    pix_en_s = en_s;
    @(negedge Clk);
  endtask

  task automatic advance();
    @(posedge Clk);
    #1;
    if (pix_en_d) pd = (pd + 1) % (DHT * DVT);
    if (pix_en_s) ps = (ps + 1) % (SHT * SVT);
  endtask

  // Called just after a rising edge; reset is pulsed well clear of both edges.
  task automatic do_reset();
    pix_en_d = 1'b0;
    pix_en_s = 1'b0;
    reset = 1'b1;
    #1;
    pd = 0;
    ps = 0;
    cmp_all("async_rst");
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vec_t tbl[12];
    int   dle[$];
    int   sfe[$];
    int   lows[$];
    int   svo[$];
    int   low_cnt;
    int   vo_cnt;

    reset = 1'b1;
    pix_en_d = 1'b0;
    pix_en_s = 1'b0;
    @(negedge Clk);
    cmp_all("reset");
    @(posedge Clk);
    #1;
    reset = 1'b0;

    // Small-timing opening sequence: holds on idle cycles, hsync window 5..6, line wrap.
    tbl[0]  = '{1, '{0, 0, 0, 0, 1, 0, 0}};
    tbl[1]  = '{0, '{1, 0, 0, 0, 1, 0, 0}};
    tbl[2]  = '{1, '{1, 0, 0, 0, 1, 0, 0}};
    tbl[3]  = '{1, '{2, 0, 0, 0, 1, 0, 0}};
    tbl[4]  = '{1, '{3, 0, 0, 0, 1, 0, 0}};
    tbl[5]  = '{1, '{4, 0, 0, 0, 0, 0, 0}};
    tbl[6]  = '{1, '{5, 0, 1, 0, 0, 0, 0}};
    tbl[7]  = '{0, '{6, 0, 1, 0, 0, 0, 0}};
    tbl[8]  = '{1, '{6, 0, 1, 0, 0, 0, 0}};
    tbl[9]  = '{0, '{7, 0, 0, 0, 0, 0, 0}};
    tbl[10] = '{1, '{7, 0, 0, 0, 0, 1, 0}};
    tbl[11] = '{1, '{0, 1, 0, 0, 1, 0, 0}};
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, tbl[i].en != 0);
      cmp_obs($sformatf("tbl%0d", i), obs_s(), tbl[i].exp);
      advance();
    end

    // Continuous pix_en: line period, hsync low width, small frame period and visible area.
    low_cnt = 0;
    vo_cnt = 0;
    for (int c = 0; c < 1700; c++) begin
      apply(1'b1, 1'b1);
      cmp_all("run");
      if (!d_hsync) low_cnt++;
      if (s_video_on) vo_cnt++;
      if (d_line_end) begin dle.push_back(c); lows.push_back(low_cnt); low_cnt = 0; end
      if (s_frame_end) begin sfe.push_back(c); svo.push_back(vo_cnt); vo_cnt = 0; end
      advance();
    end
    for (int i = 1; i < dle.size(); i++) chk("line_period", dle[i] - dle[i-1], 800);
    for (int i = 0; i < lows.size(); i++) chk("hsync_low_cycles", lows[i], 96);
    for (int i = 1; i < sfe.size(); i++) chk("small_frame_period", sfe[i] - sfe[i-1], 48);
    for (int i = 1; i < svo.size(); i++) chk("small_visible_pixels", svo[i], 12);
    chk("line_end_seen", dle.size(), 2);

    // pix_en one cycle in four.
    @(posedge Clk);
    #1;
    do_reset();
    dle.delete();
    sfe.delete();
    for (int c = 0; c < 7000; c++) begin
      apply(c % 4 == 0, c % 4 == 0);
      cmp_all("quarter");
      if (d_line_end) dle.push_back(c);
      if (s_frame_end) sfe.push_back(c);
      advance();
    end
    chk("quarter_line_count", dle.size(), 2);
    for (int i = 1; i < dle.size(); i++) chk("quarter_line_period", dle[i] - dle[i-1], 3200);
    for (int i = 1; i < sfe.size(); i++) chk("quarter_small_frame_period", sfe[i] - sfe[i-1], 192);

    // Asynchronous reset mid-line, then the first enabled edge must give hcount=1.
    do_reset();
    for (int c = 0; c < 1100; c++) begin
      apply(1'b1, 1'b1);
      cmp_all("pre_rst");
      advance();
    end
    chk("pre_rst_hcount", int'(d_hcount), 300);
    #2;
    reset = 1'b1;
    #1;
    pd = 0;
    ps = 0;
    cmp_all("midline_rst");
    reset = 1'b0;
    apply(1'b1, 1'b1);
    cmp_all("post_rst");
    advance();
    chk("first_edge_hcount", int'(d_hcount), 1);
    chk("first_edge_small_hcount", int'(s_hcount), 1);

    // Random enables with occasional asynchronous resets.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      apply($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      cmp_all("rand");
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
